// File: rtl/cpu_perf_pkg.sv
// Shared constants for the CPU performance monitor: event channel map,
// FSM encoding and read-port address width.
package cpu_perf_pkg;

    // Event channel assignments on event_vld
    localparam int EV_INST_RETIRE = 0;
    localparam int EV_ICACHE_REQ  = 1;
    localparam int EV_ICACHE_HIT  = 2;
    localparam int EV_DCACHE_REQ  = 3;
    localparam int EV_DCACHE_HIT  = 4;
    localparam int EV_STALL       = 5;
    localparam int EV_FLUSH       = 6;
    localparam int EV_MEM_WRITE   = 7;

    // Read-port address width (covers up to 16 events plus the cycle slot)
    localparam int RD_AW = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_HALTED  = 2'd2,
        ST_TIMEOUT = 2'd3
    } perf_state_e;

endpackage

// File: rtl/perf_counter.sv
// One statistics counter with synchronous clear and a sticky overflow flag.
// An increment at all-ones either holds (saturating) or wraps to zero.
module perf_counter #(
    parameter int CNT_W    = 32,
    parameter bit SAT_MODE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] value,
    output logic             ovf
);

    logic [CNT_W-1:0] value_q, value_d;
    logic             ovf_q, ovf_d;

    // Next count: clear dominates, otherwise increment with overflow handling
    always_comb begin
        value_d = value_q;
        ovf_d   = ovf_q;
        if (clr) begin
            value_d = '0;
            ovf_d   = 1'b0;
        end else if (inc) begin
            if (&value_q) begin
                ovf_d   = 1'b1;
                value_d = SAT_MODE ? value_q : '0;
            end else begin
                value_d = value_q + CNT_W'(1);
            end
        end
    end

    // Counter state register, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            value_q <= value_d;
            ovf_q   <= ovf_d;
        end
    end

    assign value = value_q;
    assign ovf   = ovf_q;

endmodule

// File: rtl/cpu_perf_monitor.sv
// CPU performance monitor: per-event counters plus a run-cycle counter,
// gated by a small run/halt/timeout FSM, with a shadow snapshot bank that
// backs a registered read port.
module cpu_perf_monitor
    import cpu_perf_pkg::*;
#(
    parameter int          NUM_EVENTS = 8,
    parameter int          CNT_W      = 32,
    parameter bit          SAT_MODE   = 1'b1,
    parameter int unsigned WDOG_LIMIT = 100000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [NUM_EVENTS-1:0] event_vld,
    input  logic                  halt,
    input  logic                  clear,
    input  logic                  snap_req,
    output logic                  snap_done,
    input  logic                  rd_en,
    input  logic [RD_AW-1:0]      rd_addr,
    output logic [CNT_W-1:0]      rd_data,
    output logic                  rd_valid,
    output logic                  rd_err,
    output logic [NUM_EVENTS:0]   ovf,
    output logic                  running,
    output logic                  halted,
    output logic                  wdog_trip
);

    // Slot NUM_EVENTS of every counter-indexed vector is the cycle counter
    localparam int          CYC    = NUM_EVENTS;
    localparam logic [64:0] WDOG_L = 65'(WDOG_LIMIT);

    perf_state_e state_q, state_d;

    logic                             count_en;
    logic [NUM_EVENTS:0]              inc_vec;
    logic [NUM_EVENTS:0][CNT_W-1:0]   live;
    logic [NUM_EVENTS:0][CNT_W-1:0]   shadow_q, shadow_d;
    logic [64:0]                      cyc_next;
    logic                             wdog_hit;
    logic                             snap_done_q, snap_done_d;
    logic [CNT_W-1:0]                 rd_data_q, rd_data_d;
    logic                             rd_valid_q, rd_valid_d;
    logic                             rd_err_q, rd_err_d;

    // Counting happens only in RUN; a concurrent clear suppresses it.
    // The halt cycle itself still counts, so the halting instruction retires.
    assign count_en = (state_q == ST_RUN) && !clear;
    assign inc_vec  = {count_en, event_vld & {NUM_EVENTS{count_en}}};

    for (genvar g = 0; g <= NUM_EVENTS; g++) begin : g_cnt
        perf_counter #(.CNT_W(CNT_W), .SAT_MODE(SAT_MODE)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clear),
            .inc   (inc_vec[g]),
            .value (live[g]),
            .ovf   (ovf[g])
        );
    end

    // Watchdog compares the unwrapped post-increment cycle count to the limit
    assign cyc_next = 65'(live[CYC]) + 65'd1;
    assign wdog_hit = (WDOG_LIMIT != 0) && (cyc_next == WDOG_L);

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state: halt beats the watchdog; HALTED/TIMEOUT wait for clear
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (enable) state_d = ST_RUN;
                ST_RUN: begin
                    if (halt)          state_d = ST_HALTED;
                    else if (wdog_hit) state_d = ST_TIMEOUT;
                end
                default: state_d = state_q;
            endcase
        end
    end

    // FSM outputs decoded from the current state
    always_comb begin
        running   = (state_q == ST_RUN);
        halted    = (state_q == ST_HALTED);
        wdog_trip = (state_q == ST_TIMEOUT);
    end

    // Snapshot captures pre-increment live values; clear leaves shadows alone
    always_comb begin
        shadow_d    = shadow_q;
        snap_done_d = snap_req;
        if (snap_req) shadow_d = live;
    end

    // Read decode from the shadow bank only; unmapped addresses flag rd_err
    always_comb begin
        rd_valid_d = rd_en;
        rd_err_d   = 1'b0;
        rd_data_d  = rd_data_q;
        if (rd_en) begin
            rd_data_d = '0;
            rd_err_d  = 1'b1;
            for (int i = 0; i <= NUM_EVENTS; i++) begin
                if (rd_addr == RD_AW'(i)) begin
                    rd_data_d = shadow_q[i];
                    rd_err_d  = 1'b0;
                end
            end
        end
    end

    // Shadow bank and read-port registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_q    <= '0;
            snap_done_q <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_err_q    <= 1'b0;
        end else begin
            shadow_q    <= shadow_d;
            snap_done_q <= snap_done_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            rd_err_q    <= rd_err_d;
        end
    end

    assign snap_done = snap_done_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign rd_err    = rd_err_q;

endmodule

// File: tb/tb_cpu_perf_monitor.sv
// Directed bench for cpu_perf_monitor. Three instances share stimulus:
// main (32-bit, watchdog 50), sat (8-bit saturating), wrap (8-bit wrapping).
// Read expectations go into a scoreboard queue when a read is issued and
// are popped when the read data comes back.
module tb_cpu_perf_monitor;
    import cpu_perf_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, enable, halt, clear, snap_req, rd_en;
    logic [7:0] event_vld;
    logic [4:0] rd_addr;

    logic        m_snap_done, m_rd_valid, m_rd_err, m_running, m_halted, m_wdog;
    logic [31:0] m_rd_data;
    logic [8:0]  m_ovf;
    logic        s_snap_done, s_rd_valid, s_rd_err, s_running, s_halted, s_wdog;
    logic [7:0]  s_rd_data;
    logic [8:0]  s_ovf;
    logic        w_snap_done, w_rd_valid, w_rd_err, w_running, w_halted, w_wdog;
    logic [7:0]  w_rd_data;
    logic [8:0]  w_ovf;

    cpu_perf_monitor #(.NUM_EVENTS(8), .CNT_W(32), .SAT_MODE(1'b1), .WDOG_LIMIT(50)) u_main (
        .clk(clk), .rst_n(rst_n), .enable(enable), .event_vld(event_vld), .halt(halt),
        .clear(clear), .snap_req(snap_req), .snap_done(m_snap_done), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_data(m_rd_data), .rd_valid(m_rd_valid), .rd_err(m_rd_err),
        .ovf(m_ovf), .running(m_running), .halted(m_halted), .wdog_trip(m_wdog));

    cpu_perf_monitor #(.NUM_EVENTS(8), .CNT_W(8), .SAT_MODE(1'b1), .WDOG_LIMIT(0)) u_sat (
        .clk(clk), .rst_n(rst_n), .enable(enable), .event_vld(event_vld), .halt(halt),
        .clear(clear), .snap_req(snap_req), .snap_done(s_snap_done), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_data(s_rd_data), .rd_valid(s_rd_valid), .rd_err(s_rd_err),
        .ovf(s_ovf), .running(s_running), .halted(s_halted), .wdog_trip(s_wdog));

    cpu_perf_monitor #(.NUM_EVENTS(8), .CNT_W(8), .SAT_MODE(1'b0), .WDOG_LIMIT(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .enable(enable), .event_vld(event_vld), .halt(halt),
        .clear(clear), .snap_req(snap_req), .snap_done(w_snap_done), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_data(w_rd_data), .rd_valid(w_rd_valid), .rd_err(w_rd_err),
        .ovf(w_ovf), .running(w_running), .halted(w_halted), .wdog_trip(w_wdog));

    typedef struct {
        int          sel;
        logic [31:0] data;
        logic        err;
        string       tag;
    } rd_exp_t;

    rd_exp_t sb[$];
    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic rd_valid_of(input int sel);
        case (sel)
            0:       return m_rd_valid;
            1:       return s_rd_valid;
            default: return w_rd_valid;
        endcase
    endfunction

    function automatic logic rd_err_of(input int sel);
        case (sel)
            0:       return m_rd_err;
            1:       return s_rd_err;
            default: return w_rd_err;
        endcase
    endfunction

    function automatic logic [31:0] rd_data_of(input int sel);
        case (sel)
            0:       return m_rd_data;
            1:       return {24'd0, s_rd_data};
            default: return {24'd0, w_rd_data};
        endcase
    endfunction

    // Issue one read, compare the returned word against the scoreboard head,
    // then confirm rd_valid lasts a single cycle.
    task automatic do_read(input int sel, input logic [4:0] a, input logic [31:0] d,
                           input logic e, input string tag);
        rd_exp_t x;
        rd_exp_t got;
        x.sel = sel; x.data = d; x.err = e; x.tag = tag;
        sb.push_back(x);
        rd_en   = 1'b1;
        rd_addr = a;
        tick();
        rd_en = 1'b0;
        chk({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            got = sb.pop_front();
            chk({got.tag, "_valid"}, 64'(rd_valid_of(got.sel)), 64'd1);
            chk({got.tag, "_data"},  64'(rd_data_of(got.sel)),  64'(got.data));
            chk({got.tag, "_err"},   64'(rd_err_of(got.sel)),   64'(got.err));
        end
        tick();
        chk({tag, "_valid_drop"}, 64'(rd_valid_of(sel)), 64'd0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic do_enable();
        enable = 1'b1;
        tick();
        enable = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; halt = 1'b0; clear = 1'b0;
        snap_req = 1'b0; rd_en = 1'b0; event_vld = 8'h00; rd_addr = 5'd0;

        // ---- reset state
        tick(); tick();
        chk("rst_running",   64'(m_running),   64'd0);
        chk("rst_halted",    64'(m_halted),    64'd0);
        chk("rst_wdog",      64'(m_wdog),      64'd0);
        chk("rst_rd_valid",  64'(m_rd_valid),  64'd0);
        chk("rst_rd_err",    64'(m_rd_err),    64'd0);
        chk("rst_rd_data",   64'(m_rd_data),   64'd0);
        chk("rst_ovf",       64'(m_ovf),       64'd0);
        chk("rst_snap_done", 64'(m_snap_done), 64'd0);
        rst_n = 1'b1;

        // ---- basic run: 1 idle RUN cycle, then 10 retire cycles with halt on the 10th
        do_enable();
        chk("t1_running", 64'(m_running), 64'd1);
        tick();
        event_vld = 8'h01;
        repeat (9) tick();
        halt = 1'b1;
        tick();
        halt = 1'b0; event_vld = 8'h00;
        chk("t1_halted",  64'(m_halted),  64'd1);
        chk("t1_running_off", 64'(m_running), 64'd0);
        tick();
        chk("t1_frozen_halted", 64'(m_halted), 64'd1);
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        chk("t1_snap_done", 64'(m_snap_done), 64'd1);
        tick();
        chk("t1_snap_done_drop", 64'(m_snap_done), 64'd0);
        do_read(0, 5'd0, 32'd10, 1'b0, "t1_ev0");
        do_read(0, 5'd8, 32'd11, 1'b0, "t1_cyc");

        // ---- 300 cycles of ICACHE_HIT: saturate vs wrap; main trips watchdog at 50
        do_clear();
        chk("t2_idle", 64'(m_running), 64'd0);
        chk("t2_ovf_cleared", 64'(m_ovf), 64'd0);
        do_enable();
        event_vld = 8'h04;
        repeat (49) tick();
        chk("t2_no_early_trip", 64'(m_wdog), 64'd0);
        repeat (251) tick();
        event_vld = 8'h00;
        chk("t2_main_wdog",     64'(m_wdog),    64'd1);
        chk("t2_main_not_halt", 64'(m_halted),  64'd0);
        chk("t2_sat_running",   64'(s_running), 64'd1);
        chk("t2_sat_ovf",       64'(s_ovf),     64'h104);
        chk("t2_wrap_ovf",      64'(w_ovf),     64'h104);
        chk("t2_main_ovf",      64'(m_ovf),     64'd0);
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        do_read(1, 5'd2, 32'd255, 1'b0, "t2_sat_ev2");
        do_read(2, 5'd2, 32'd44,  1'b0, "t2_wrap_ev2");
        do_read(0, 5'd8, 32'd50,  1'b0, "t2_main_cyc");
        do_read(0, 5'd2, 32'd50,  1'b0, "t2_main_ev2");

        // ---- halt coinciding with the watchdog limit: halt wins
        do_clear();
        do_enable();
        repeat (49) tick();
        chk("t3_running", 64'(m_running), 64'd1);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("t3_halted", 64'(m_halted), 64'd1);
        chk("t3_wdog",   64'(m_wdog),   64'd0);

        // ---- clear + event + snapshot in the same cycle
        do_clear();
        do_enable();
        event_vld = 8'h08;
        repeat (7) tick();
        clear = 1'b1; snap_req = 1'b1;
        tick();
        clear = 1'b0; snap_req = 1'b0; event_vld = 8'h00;
        chk("t4_idle_running", 64'(m_running),   64'd0);
        chk("t4_idle_halted",  64'(m_halted),    64'd0);
        chk("t4_snap_done",    64'(m_snap_done), 64'd1);
        // read concurrent with a snapshot returns the older shadow (7)
        snap_req = 1'b1;
        do_read(0, 5'd3, 32'd7, 1'b0, "t4_shadow3");
        snap_req = 1'b0;
        do_read(0, 5'd3, 32'd0, 1'b0, "t4_live3");
        chk("t4_still_idle", 64'(m_running), 64'd0);

        // ---- invalid read addresses
        do_read(0, 5'd20, 32'd0, 1'b1, "t5_addr20");
        do_read(0, 5'd9,  32'd0, 1'b1, "t5_addr9");

        // ---- synchronous reset mid-RUN
        do_enable();
        event_vld = 8'hFF;
        repeat (5) tick();
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        do_read(0, 5'd0, 32'd5, 1'b0, "t6_pre_rst");
        rst_n = 1'b0; rd_en = 1'b1; rd_addr = 5'd0; snap_req = 1'b1;
        tick();
        rst_n = 1'b1; rd_en = 1'b0; snap_req = 1'b0; event_vld = 8'h00;
        chk("t6_running",   64'(m_running),   64'd0);
        chk("t6_rd_valid",  64'(m_rd_valid),  64'd0);
        chk("t6_rd_data",   64'(m_rd_data),   64'd0);
        chk("t6_rd_err",    64'(m_rd_err),    64'd0);
        chk("t6_snap_done", 64'(m_snap_done), 64'd0);
        chk("t6_ovf",       64'(s_ovf),       64'd0);
        do_read(0, 5'd0, 32'd0, 1'b0, "t6_shadow_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
